gmii_tx_arbiter: RTL and testbench
==================================

Name: gmii_tx_arbiter

Overview:
- Shares one single-byte GMII transmit bus between pPORTS frame sources, such as pcap replay sources or receiver-side frame buffers.
- Grants are frame-atomic and round-robin.
- Enforces a minimum inter-frame idle gap after every frame.
- Detects grant start timeouts and illegal traffic from non-granted ports.
- Sits between the per-port frame generators and the single GMII sink in the switch receive/transmit test and datapath.

Parameters:
pPORTS, 4, number of requesters (2..8)
pIPG_LENGTH, 12, cycles spent in stIPG after each frame end (>=1)
pSTART_TIMEOUT, 64, max cycles a granted port may take to assert ival before the grant is revoked (>=2)

Ports:
iclk  in  1  clock; all logic on posedge
irst  in  1  synchronous active-high reset
ireq  in  pPORTS  per-port frame-ready request; level, held until grant
ival  in  pPORTS  per-port byte valid
idata  in  8*pPORTS  per-port byte; port i occupies bits [8i+7:8i]
ogrant  out  pPORTS  one-hot grant; all zero when no grant
oval  out  1  GMII tx valid
odata  out  8  GMII tx data
ocur_port  out  $clog2(pPORTS)  index of the last granted port
opkt_cnt  out  8  frames forwarded, wraps 255->0
oerr_timeout  out  1  one-cycle pulse when a grant is revoked for start timeout
ocollision  out  1  one-cycle pulse when any non-granted port asserts ival

Behaviour:

Reset (irst=1 at an edge):
- ogrant=0, oval=0, odata=0, opkt_cnt=0, oerr_timeout=0, ocollision=0, ocur_port=pPORTS-1.
- State goes to stIDLE and the round-robin pointer is set so port 0 has top priority.
- Reset mid-frame truncates the frame; no FCS or padding is added.

State stIDLE:
- If any ireq bit is set, grant the first requesting port found by searching from (ocur_port+1) mod pPORTS upward with wrap.
- On that edge: ogrant[g]<=1, ocur_port<=g, timeout counter<=pSTART_TIMEOUT-1, state stGRANT.
- If no ireq bit is set, stay in stIDLE.

State stGRANT:
- ival[g]=1: oval<=1, odata<=idata[g], state stXFER.
- Else if the counter is 0: ogrant<=0, oerr_timeout<=1, state stIPG with the gap counter loaded.
- Else decrement the counter.
- ireq[g] is ignored once the grant is issued.

State stXFER:
- ival[g]=1: oval<=1, odata<=idata[g].
- ival[g]=0: end of frame. oval<=0, odata<=0, ogrant<=0, opkt_cnt<=opkt_cnt+1, gap counter<=pIPG_LENGTH-1, state stIPG.
- Any ival gap ends the frame; sources must stream contiguously, with preamble and SFD supplied by the source.

State stIPG:
- oval=0, odata=0.
- Decrement the gap counter; when it is 0, go to stIDLE. Total time in stIPG is pIPG_LENGTH cycles.

Datapath:
- Latency from ival/idata of the granted port to oval/odata is exactly 1 cycle, registered.
- Bytes are forwarded unmodified.

Collision detection:
- ocollision<=1 for one cycle whenever (ival & ~ogrant) != 0, in any state.
- Data from such ports is never forwarded, and arbitration state is unaffected.

Invariants:
- ogrant is always one-hot or zero.
- oval=1 implies the previous-cycle ogrant was nonzero.
- A port cannot be re-granted while another requester is pending, which gives round-robin fairness.

Test Plan:
1. Single port: ireq[0]=1; source asserts ival the cycle after ogrant[0] rises and sends 8'h55 x7, 8'hD5, 60 data bytes -> oval high 68 contiguous cycles; odata equals the source bytes delayed 1 cycle; opkt_cnt=1; ocur_port=0.
2. Back-to-back, same configuration: port 0 sends two frames, pIPG_LENGTH=12 -> exactly 15 oval=0 cycles between the last byte of frame 1 and the first byte of frame 2; opkt_cnt=2.
3. Round-robin: all four ireq held high, each port sends a 10-byte frame per grant -> grant order 0,1,2,3,0,1; no port is granted twice in a row; opkt_cnt increments per frame.
4. Timeout: pSTART_TIMEOUT=64, port 2 requests but never asserts ival -> ogrant[2] drops after 64 cycles in stGRANT; oerr_timeout pulses once; opkt_cnt unchanged; next grant goes to port 3 if it is requesting.
5. Collision: port 1 granted and transferring, port 3 asserts ival for 2 cycles -> ocollision high for 2 cycles, one cycle late; odata carries only port 1 bytes.
6. Reset mid-frame: irst=1 during byte 20 of a frame -> next cycle oval=0, ogrant=0, opkt_cnt=0; after release, with ports 0 and 2 requesting, port 0 is granted first.

Source files
------------

// File: rtl/gmii_tx_arbiter_if.sv
// gmii_tx_arbiter_if: per-port frame source bus and shared GMII transmit bus of the arbiter
interface gmii_tx_arbiter_if #(
  parameter int pPORTS = 4
);
  logic [pPORTS-1:0]         ireq;
  logic [pPORTS-1:0]         ival;
  logic [8*pPORTS-1:0]       idata;
  logic [pPORTS-1:0]         ogrant;
  logic                      oval;
  logic [7:0]                odata;
  logic [$clog2(pPORTS)-1:0] ocur_port;
  logic [7:0]                opkt_cnt;
  logic                      oerr_timeout;
  logic                      ocollision;
  modport master (
    output ireq, ival, idata,
    input  ogrant, oval, odata, ocur_port, opkt_cnt, oerr_timeout, ocollision
  );
  modport slave (
    input  ireq, ival, idata,
    output ogrant, oval, odata, ocur_port, opkt_cnt, oerr_timeout, ocollision
  );
endinterface

// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter: frame-atomic round-robin arbiter sharing one GMII tx bus with idle gap and error detection
module gmii_tx_arbiter #(
  parameter int pPORTS         = 4,
  parameter int pIPG_LENGTH    = 12,
  parameter int pSTART_TIMEOUT = 64
) (
  input logic             iclk,
  input logic             irst,
  gmii_tx_arbiter_if.slave bus
);
  localparam int CUR_W = $clog2(pPORTS);
  localparam int MAX_C = pSTART_TIMEOUT > pIPG_LENGTH ? pSTART_TIMEOUT : pIPG_LENGTH;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [pPORTS-1:0] ONE = 1;
  typedef enum logic [1:0] {stIDLE, stGRANT, stXFER, stIPG} state_t;
  state_t            r_state, w_state;
  logic [pPORTS-1:0] r_grant, w_grant;
  logic [CUR_W-1:0]  r_cur, w_cur, w_hi, w_lo, w_pick;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic              r_val, w_val, r_to, w_to, r_col, w_col, w_hi_found, w_gval;
  logic [7:0]        r_data, w_data, r_pkt, w_pkt, w_gdata;
  always_comb begin
    w_hi_found = 1'b0;
    w_hi = '0;
    w_lo = '0;
    for (int i = pPORTS - 1; i >= 0; i--) begin
      if (bus.ireq[i]) begin
        w_lo = CUR_W'(i);
        if (i > int'(r_cur)) begin
          w_hi_found = 1'b1;
          w_hi = CUR_W'(i);
        end
      end
    end
    w_pick = w_hi_found ? w_hi : w_lo;
  end
  always_comb begin
    w_gdata = '0;
    for (int i = 0; i < pPORTS; i++)
      if (r_grant[i]) w_gdata = bus.idata[8*i +: 8];
    w_gval = |(bus.ival & r_grant);
  end
  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_cur   = r_cur;
    w_cnt   = r_cnt;
    w_val   = 1'b0;
    w_data  = '0;
    w_pkt   = r_pkt;
    w_to    = 1'b0;
    w_col   = |(bus.ival & ~r_grant);
    case (r_state)
      stIDLE:
        if (|bus.ireq) begin
          w_grant = ONE << w_pick;
          w_cur   = w_pick;
          w_cnt   = CNT_W'(pSTART_TIMEOUT - 1);
          w_state = stGRANT;
        end
      stGRANT:
        if (w_gval) begin
          w_val   = 1'b1;
          w_data  = w_gdata;
          w_state = stXFER;
        end else if (r_cnt == '0) begin
          w_grant = '0;
          w_to    = 1'b1;
          w_cnt   = CNT_W'(pIPG_LENGTH - 1);
          w_state = stIPG;
        end else w_cnt = r_cnt - CNT_W'(1);
      stXFER:
        if (w_gval) begin
          w_val  = 1'b1;
          w_data = w_gdata;
        end else begin
          w_grant = '0;
          w_pkt   = r_pkt + 8'd1;
          w_cnt   = CNT_W'(pIPG_LENGTH - 1);
          w_state = stIPG;
        end
      stIPG:
        if (r_cnt == '0) w_state = stIDLE;
        else w_cnt = r_cnt - CNT_W'(1);
      default: w_state = stIDLE;
    endcase
  end
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state <= stIDLE;
      r_grant <= '0;
      r_cur   <= CUR_W'(pPORTS - 1);
      r_cnt   <= '0;
      r_val   <= 1'b0;
      r_data  <= '0;
      r_pkt   <= '0;
      r_to    <= 1'b0;
      r_col   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_cur   <= w_cur;
      r_cnt   <= w_cnt;
      r_val   <= w_val;
      r_data  <= w_data;
      r_pkt   <= w_pkt;
      r_to    <= w_to;
      r_col   <= w_col;
    end
  end
  assign bus.ogrant       = r_grant;
  assign bus.oval         = r_val;
  assign bus.odata        = r_data;
  assign bus.ocur_port    = r_cur;
  assign bus.opkt_cnt     = r_pkt;
  assign bus.oerr_timeout = r_to;
  assign bus.ocollision   = r_col;
endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// tb_gmii_tx_arbiter: directed self-checking bench for the GMII tx arbiter
module tb_gmii_tx_arbiter;
  logic iclk = 1'b0;
  logic irst = 1'b1;
  gmii_tx_arbiter_if #(.pPORTS(4)) bus();
  gmii_tx_arbiter #(.pPORTS(4), .pIPG_LENGTH(12), .pSTART_TIMEOUT(64)) dut (
    .iclk(iclk),
    .irst(irst),
    .bus (bus)
  );
  always #5 iclk = ~iclk;
  int n_chk = 0;
  int n_err = 0;
  logic [7:0] q_out[$];
  logic [7:0] q_exp[$];
  int q_run[$];
  int q_gap[$];
  int q_port[$];
  int run = 0;
  int gap = 0;
  int n_col = 0;
  int n_to = 0;
  logic seen = 1'b0;
  logic prev_oval = 1'b0;
  logic prev_gv = 1'b0;
  logic bad_oh = 1'b0;
  logic bad_pg = 1'b0;
  logic bad_lat = 1'b0;
  logic clr_req = 1'b0;
  logic [3:0] prev_grant = '0;
  logic [7:0] prev_gd = '0;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  always @(negedge iclk) begin
    if (clr_req) begin
      q_out.delete();
      q_run.delete();
      q_gap.delete();
      run = 0;
      gap = 0;
      seen = 1'b0;
      n_col = 0;
      n_to = 0;
      bad_oh = 1'b0;
      bad_pg = 1'b0;
      bad_lat = 1'b0;
    end else begin
      if (bus.oval) begin
        if (!prev_oval && seen) q_gap.push_back(gap);
        q_out.push_back(bus.odata);
        run++;
        if (prev_grant == '0) bad_pg = 1'b1;
        if (!(prev_gv && bus.odata == prev_gd)) bad_lat = 1'b1;
      end else begin
        if (prev_oval) begin
          q_run.push_back(run);
          run = 0;
          gap = 0;
          seen = 1'b1;
        end
        gap++;
      end
      if ($countones(bus.ogrant) > 1) bad_oh = 1'b1;
      n_col = n_col + int'(bus.ocollision);
      n_to = n_to + int'(bus.oerr_timeout);
    end
    prev_oval = bus.oval;
    prev_grant = bus.ogrant;
    prev_gv = |(bus.ival & bus.ogrant);
    prev_gd = '0;
    for (int i = 0; i < 4; i++)
      if (bus.ogrant[i]) prev_gd = bus.idata[8*i +: 8];
  end
  initial begin
    #500000;
    $display("FAIL watchdog got %0d exp %0d", n_chk, -1);
    $fatal(1, "watchdog expired");
  end
  task automatic tick();
    @(posedge iclk);
    #1;
  endtask
  task automatic clr();
    clr_req = 1'b1;
    @(negedge iclk);
    #1;
    clr_req = 1'b0;
    q_exp.delete();
    q_port.delete();
    tick();
  endtask
  task automatic do_reset();
    irst = 1'b1;
    bus.ireq = '0;
    bus.ival = '0;
    bus.idata = '0;
    tick();
    tick();
    irst = 1'b0;
  endtask
  function automatic logic [7:0] fb(input logic pre, input logic [7:0] base, input int k);
    return (pre && k < 7) ? 8'h55 : (pre && k == 7) ? 8'hD5 : base + 8'(k);
  endfunction
  task automatic wait_grant(output int p);
    int w = 0;
    p = -1;
    while (bus.ogrant == '0 && w < 300) begin
      tick();
      w++;
    end
    if (bus.ogrant == '0) check("grant_wait", 0, 1);
    for (int i = 0; i < 4; i++)
      if (bus.ogrant[i]) p = i;
  endtask
  task automatic send_frame(input int n, input logic pre, input logic [7:0] base,
                            input int cp, input int col_at, input int rst_at);
    int p;
    logic [7:0] b;
    wait_grant(p);
    if (p < 0) return;
    q_port.push_back(p);
    tick();
    for (int k = 0; k < n; k++) begin
      b = fb(pre, base, k);
      bus.ival = '0;
      bus.ival[p] = 1'b1;
      bus.idata[8*p +: 8] = b;
      if (cp >= 0) begin
        bus.ival[cp] = (k == col_at || k == col_at + 1);
        bus.idata[8*cp +: 8] = 8'hEE;
      end
      if (k == rst_at) irst = 1'b1;
      else q_exp.push_back(b);
      tick();
      if (k == rst_at) begin
        check("rst_mid_oval", bus.oval, 0);
        check("rst_mid_grant", bus.ogrant, 0);
        check("rst_mid_pkt", bus.opkt_cnt, 0);
        check("rst_mid_cur", bus.ocur_port, 3);
        irst = 1'b0;
        bus.ival = '0;
        bus.idata = '0;
        return;
      end
      if (cp >= 0 && k >= col_at - 1 && k <= col_at + 2)
        check("col_pulse", bus.ocollision, int'(k == col_at || k == col_at + 1));
    end
    bus.ival = '0;
    bus.idata = '0;
    tick();
  endtask
  task automatic cmp_data(input string tag);
    int nm = 0;
    for (int i = 0; i < q_out.size() && i < q_exp.size(); i++)
      if (q_out[i] != q_exp[i]) nm++;
    check({tag, "_len"}, q_out.size(), q_exp.size());
    check({tag, "_bytes"}, nm, 0);
  endtask
  task automatic end_test(input string tag);
    check({tag, "_onehot"}, bad_oh, 0);
    check({tag, "_val_after_grant"}, bad_pg, 0);
    check({tag, "_latency"}, bad_lat, 0);
  endtask
  initial begin
    int p;
    int cnt;
    do_reset();
    clr();
    check("rst_grant", bus.ogrant, 0);
    check("rst_oval", bus.oval, 0);
    check("rst_odata", bus.odata, 0);
    check("rst_pkt", bus.opkt_cnt, 0);
    check("rst_to", bus.oerr_timeout, 0);
    check("rst_col", bus.ocollision, 0);
    check("rst_cur", bus.ocur_port, 3);
    bus.ireq = 4'b0001;
    send_frame(68, 1'b1, 8'h10, -1, -1, -1);
    bus.ireq = '0;
    repeat (4) tick();
    check("t1_runs", q_run.size(), 1);
    check("t1_run_len", q_run.size() > 0 ? q_run[0] : -1, 68);
    cmp_data("t1_data");
    check("t1_pkt", bus.opkt_cnt, 1);
    check("t1_cur", bus.ocur_port, 0);
    end_test("t1");
    do_reset();
    clr();
    bus.ireq = 4'b0001;
    send_frame(20, 1'b1, 8'h20, -1, -1, -1);
    send_frame(20, 1'b1, 8'h40, -1, -1, -1);
    bus.ireq = '0;
    repeat (4) tick();
    check("t2_gaps", q_gap.size(), 1);
    check("t2_gap_len", q_gap.size() > 0 ? q_gap[0] : -1, 15);
    check("t2_pkt", bus.opkt_cnt, 2);
    cmp_data("t2_data");
    end_test("t2");
    do_reset();
    clr();
    bus.ireq = 4'b1111;
    for (int f = 0; f < 6; f++) send_frame(10, 1'b0, 8'(16 * f), -1, -1, -1);
    bus.ireq = '0;
    repeat (4) tick();
    for (int f = 0; f < 6; f++) check("t3_order", f < q_port.size() ? q_port[f] : -1, f % 4);
    check("t3_pkt", bus.opkt_cnt, 6);
    check("t3_col", n_col, 0);
    cmp_data("t3_data");
    end_test("t3");
    do_reset();
    clr();
    bus.ireq = 4'b1100;
    wait_grant(p);
    check("t4_port", p, 2);
    cnt = 0;
    while (bus.ogrant[2] && cnt < 200) begin
      cnt++;
      tick();
    end
    check("t4_grant_cycles", cnt, 64);
    check("t4_to_now", bus.oerr_timeout, 1);
    check("t4_grant_off", bus.ogrant, 0);
    check("t4_pkt_same", bus.opkt_cnt, 0);
    bus.ireq = 4'b1000;
    send_frame(10, 1'b0, 8'h60, -1, -1, -1);
    bus.ireq = '0;
    repeat (4) tick();
    check("t4_next_port", q_port.size() > 0 ? q_port[0] : -1, 3);
    check("t4_to_count", n_to, 1);
    check("t4_pkt", bus.opkt_cnt, 1);
    cmp_data("t4_data");
    end_test("t4");
    do_reset();
    clr();
    bus.ireq = 4'b0010;
    send_frame(30, 1'b1, 8'h80, 3, 12, -1);
    bus.ireq = '0;
    repeat (4) tick();
    check("t5_port", q_port.size() > 0 ? q_port[0] : -1, 1);
    check("t5_col_count", n_col, 2);
    check("t5_pkt", bus.opkt_cnt, 1);
    cmp_data("t5_data");
    end_test("t5");
    clr();
    bus.ireq = 4'b0101;
    send_frame(40, 1'b1, 8'hA0, -1, -1, 20);
    send_frame(10, 1'b0, 8'hC0, -1, -1, -1);
    bus.ireq = '0;
    repeat (4) tick();
    check("t6_first", q_port.size() > 0 ? q_port[0] : -1, 2);
    check("t6_after_rst", q_port.size() > 1 ? q_port[1] : -1, 0);
    check("t6_trunc_run", q_run.size() > 0 ? q_run[0] : -1, 20);
    check("t6_pkt", bus.opkt_cnt, 1);
    cmp_data("t6_data");
    end_test("t6");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
